arc4_sched: RTL

//  Top-level sequencer for the ARC4 decryption unit. On one en pulse it runs
//  the three phases in order: init (S[i]=i), then ksa, then prga. It drives each

---
 rtl/arc4_pkg.sv | 32 +++
 rtl/arc4_sched_s_port_mux.sv | 23 ++
 rtl/arc4_sched.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/arc4_pkg.sv
// Shared types for the ARC4 decryption unit: scheduler states, phase codes and
// the S-memory request bundle that each phase drives.
package arc4_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT_GO,
        ST_INIT_WAIT,
        ST_KSA_GO,
        ST_KSA_WAIT,
        ST_PRGA_GO,
        ST_PRGA_WAIT,
        ST_ERR
    } sched_state_t;

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_INIT = 2'd1,
        PH_KSA  = 2'd2,
        PH_PRGA = 2'd3
    } phase_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] wrdata;
        logic       wren;
    } smem_req_t;

    localparam int unsigned TIMEOUT_DEFAULT = 4096;
    localparam smem_req_t   SMEM_REQ_IDLE   = '0;

endpackage

// File: rtl/arc4_sched_s_port_mux.sv
// Stateless 3:1 selector that hands the single-port S memory to one phase.
// An idle selection returns an all-zero request, so no write can leak through.
module s_port_mux
    import arc4_pkg::*;
(
    input  phase_t    sel,
    input  smem_req_t init_req,
    input  smem_req_t ksa_req,
    input  smem_req_t prga_req,
    output smem_req_t req
);

    always_comb begin
        req = SMEM_REQ_IDLE;
        case (sel)
            PH_INIT: req = init_req;
            PH_KSA:  req = ksa_req;
            PH_PRGA: req = prga_req;
            default: req = SMEM_REQ_IDLE;
        endcase
    end

endmodule

// File: rtl/arc4_sched.sv
// ARC4 top-level sequencer: runs init, ksa and prga in order on one start pulse,
// arbitrates the S memory by phase and watchdogs each phase.
//
//  state      | meaning
//  -----------+---------------------------------------------------------
//  IDLE       | rdy=1, waiting for en; key captured on accept
//  INIT_GO    | pulse init_en once init_rdy is high
//  INIT_WAIT  | init running; owns S memory; first cycle ignores init_rdy
//  KSA_GO     | pulse ksa_en once ksa_rdy is high
//  KSA_WAIT   | ksa running; owns S memory
//  PRGA_GO    | pulse prga_en once prga_rdy is high
//  PRGA_WAIT  | prga running; owns S memory; done returns to IDLE
//  ERR        | a phase timed out; sticky until reset
module arc4_sched
    import arc4_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        rdy,
    output logic        err,
    output logic [1:0]  phase,
    input  logic [23:0] key,
    output logic [23:0] key_q,
    output logic        init_en,
    output logic        ksa_en,
    output logic        prga_en,
    input  logic        init_rdy,
    input  logic        ksa_rdy,
    input  logic        prga_rdy,
    input  logic [7:0]  init_addr,
    input  logic [7:0]  init_wrdata,
    input  logic        init_wren,
    input  logic [7:0]  ksa_addr,
    input  logic [7:0]  ksa_wrdata,
    input  logic        ksa_wren,
    input  logic [7:0]  prga_addr,
    input  logic [7:0]  prga_wrdata,
    input  logic        prga_wren,
    output logic [7:0]  s_addr,
    output logic [7:0]  s_wrdata,
    output logic        s_wren
);

    localparam int unsigned     CNT_W     = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic            WD_EN     = (TIMEOUT_CYCLES != 0);

    sched_state_t     state;
    phase_t           phase_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             wd_fire;
    logic             wait_first;

    logic             cur_rdy;
    sched_state_t     st_wait;
    sched_state_t     st_done;
    phase_t           ph_done;

    smem_req_t        init_req;
    smem_req_t        ksa_req;
    smem_req_t        prga_req;
    smem_req_t        s_req;

    // Per-phase view of the current state: whose rdy to watch and where to go next.
    always_comb begin
        cur_rdy = 1'b0;
        st_wait = ST_IDLE;
        st_done = ST_IDLE;
        ph_done = PH_IDLE;
        case (state)
            ST_INIT_GO, ST_INIT_WAIT: begin
                cur_rdy = init_rdy;
                st_wait = ST_INIT_WAIT;
                st_done = ST_KSA_GO;
                ph_done = PH_KSA;
            end
            ST_KSA_GO, ST_KSA_WAIT: begin
                cur_rdy = ksa_rdy;
                st_wait = ST_KSA_WAIT;
                st_done = ST_PRGA_GO;
                ph_done = PH_PRGA;
            end
            ST_PRGA_GO, ST_PRGA_WAIT: begin
                cur_rdy = prga_rdy;
                st_wait = ST_PRGA_WAIT;
                st_done = ST_IDLE;
                ph_done = PH_IDLE;
            end
            default: ;
        endcase
    end

    assign cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    assign wd_fire    = WD_EN && (cnt_inc == CNT_LIMIT);
    assign wait_first = (cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            phase_q <= PH_IDLE;
            rdy     <= 1'b1;
            err     <= 1'b0;
            key_q   <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        key_q   <= key;
                        rdy     <= 1'b0;
                        cnt     <= '0;
                        state   <= ST_INIT_GO;
                        phase_q <= PH_INIT;
                    end
                end
                ST_INIT_GO, ST_KSA_GO, ST_PRGA_GO: begin
                    if (cur_rdy) begin
                        state <= st_wait;
                        cnt   <= '0;
                    end else if (wd_fire) begin
                        state   <= ST_ERR;
                        phase_q <= PH_IDLE;
                        err     <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_INIT_WAIT, ST_KSA_WAIT, ST_PRGA_WAIT: begin
                    // A done seen on the same edge as the limit takes priority.
                    if (cur_rdy && !wait_first) begin
                        state   <= st_done;
                        phase_q <= ph_done;
                        cnt     <= '0;
                        rdy     <= (st_done == ST_IDLE);
                    end else if (wd_fire) begin
                        state   <= ST_ERR;
                        phase_q <= PH_IDLE;
                        err     <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign phase   = phase_q;
    assign init_en = (state == ST_INIT_GO) && init_rdy;
    assign ksa_en  = (state == ST_KSA_GO)  && ksa_rdy;
    assign prga_en = (state == ST_PRGA_GO) && prga_rdy;

    assign init_req = '{addr: init_addr, wrdata: init_wrdata, wren: init_wren};
    assign ksa_req  = '{addr: ksa_addr,  wrdata: ksa_wrdata,  wren: ksa_wren};
    assign prga_req = '{addr: prga_addr, wrdata: prga_wrdata, wren: prga_wren};

    s_port_mux u_s_port_mux (
        .sel      (phase_q),
        .init_req (init_req),
        .ksa_req  (ksa_req),
        .prga_req (prga_req),
        .req      (s_req)
    );

    assign s_addr   = s_req.addr;
    assign s_wrdata = s_req.wrdata;
    assign s_wren   = s_req.wren;

endmodule
